// File: rtl/down_fifo_pkg.sv
// Shared definitions for the down FIFO test-pattern writer and its read-side checker.
package down_fifo_pkg;

    localparam logic [15:0] HDR_WORD       = 16'hBE11;
    localparam int          DEF_PKT_WORDS  = 16;
    localparam int          DEF_GAP_CYCLES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_SEQ,
        ST_PAY,
        ST_CHK,
        ST_GAP
    } state_e;

    function automatic logic is_emit(input state_e s);
        return (s == ST_HDR) || (s == ST_SEQ) || (s == ST_PAY) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/down_fifo_pattern_writer.sv
// Framed test-pattern source for the 16-bit write side of the down FIFO.
//   state | meaning
//   IDLE  | no run active, waiting for start
//   HDR   | header word 16'hBE11 pending
//   SEQ   | packet sequence number pending
//   PAY   | payload words pending (running counter)
//   CHK   | checksum (SEQ xor payload) pending
//   GAP   | idle cycles between packets
module down_fifo_pattern_writer
    import down_fifo_pkg::*;
#(
    parameter int PKT_WORDS  = DEF_PKT_WORDS,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic [15:0] num_pkts_i,
    input  logic [15:0] seed_i,
    input  logic        fifo_full_i,
    output logic        fifo_wr_o,
    output logic [15:0] fifo_dat_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] pkt_cnt_o,
    output logic [31:0] stall_cnt_o
);

    localparam int WW = $clog2(PKT_WORDS + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [WW-1:0] W_LAST = WW'(PKT_WORDS - 1);
    localparam logic [GW-1:0] G_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e        state_q, state_d;
    logic [15:0]   dat_q, dat_d;
    logic [15:0]   seq_q, seq_d;
    logic [15:0]   pay_q, pay_d;
    logic [15:0]   chk_q, chk_d;
    logic [15:0]   num_q, num_d;
    logic [15:0]   pkt_q, pkt_d;
    logic [31:0]   stall_q, stall_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic          stop_q, stop_d;
    logic          done_q, done_d;
    logic          emit, wr, end_run;

    always_comb begin
        state_d = state_q;
        dat_d   = dat_q;
        seq_d   = seq_q;
        pay_d   = pay_q;
        chk_d   = chk_q;
        num_d   = num_q;
        pkt_d   = pkt_q;
        stall_d = stall_q;
        wcnt_d  = wcnt_q;
        gcnt_d  = gcnt_q;
        stop_d  = stop_q;
        done_d  = 1'b0;

        emit    = is_emit(state_q);
        wr      = emit & ~fifo_full_i;
        // A stop seen in the same cycle as the closing word still ends the run.
        end_run = stop_q | stop_i | ((num_q != 16'd0) && ((pkt_q + 16'd1) == num_q));

        if (emit && fifo_full_i && (stall_q != '1))
            stall_d = stall_q + 32'd1;
        if ((state_q != ST_IDLE) && stop_i)
            stop_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_HDR;
                    dat_d   = HDR_WORD;
                    seq_d   = 16'd0;
                    pay_d   = seed_i;
                    num_d   = num_pkts_i;
                    pkt_d   = 16'd0;
                    stall_d = 32'd0;
                    stop_d  = 1'b0;
                end
            end
            ST_HDR: begin
                if (wr) begin
                    state_d = ST_SEQ;
                    dat_d   = seq_q;
                end
            end
            ST_SEQ: begin
                if (wr) begin
                    state_d = ST_PAY;
                    dat_d   = pay_q;
                    pay_d   = pay_q + 16'd1;
                    chk_d   = seq_q;
                    wcnt_d  = '0;
                end
            end
            ST_PAY: begin
                if (wr) begin
                    chk_d = chk_q ^ dat_q;
                    if (wcnt_q == W_LAST) begin
                        state_d = ST_CHK;
                        dat_d   = chk_q ^ dat_q;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                        dat_d  = pay_q;
                        pay_d  = pay_q + 16'd1;
                    end
                end
            end
            ST_CHK: begin
                if (wr) begin
                    pkt_d = pkt_q + 16'd1;
                    seq_d = seq_q + 16'd1;
                    if (end_run) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if (GAP_CYCLES > 0) begin
                        state_d = ST_GAP;
                        gcnt_d  = G_LAST;
                    end else begin
                        state_d = ST_HDR;
                        dat_d   = HDR_WORD;
                    end
                end
            end
            ST_GAP: begin
                if (stop_q || stop_i) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (gcnt_q == '0) begin
                    state_d = ST_HDR;
                    dat_d   = HDR_WORD;
                end else begin
                    gcnt_d = gcnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            dat_q   <= 16'd0;
            seq_q   <= 16'd0;
            pay_q   <= 16'd0;
            chk_q   <= 16'd0;
            num_q   <= 16'd0;
            pkt_q   <= 16'd0;
            stall_q <= 32'd0;
            wcnt_q  <= '0;
            gcnt_q  <= '0;
            stop_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dat_q   <= dat_d;
            seq_q   <= seq_d;
            pay_q   <= pay_d;
            chk_q   <= chk_d;
            num_q   <= num_d;
            pkt_q   <= pkt_d;
            stall_q <= stall_d;
            wcnt_q  <= wcnt_d;
            gcnt_q  <= gcnt_d;
            stop_q  <= stop_d;
            done_q  <= done_d;
        end
    end

    assign fifo_wr_o   = wr;
    assign fifo_dat_o  = dat_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = done_q;
    assign pkt_cnt_o   = pkt_q;
    assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_down_fifo_pattern_writer.sv
// Bench for down_fifo_pattern_writer: cycle table, corner sequences and randomized full stress.
module tb_down_fifo_pattern_writer;

    localparam int P = 4;
    localparam int G = 2;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        start_i, stop_i, fifo_full_i;
    logic [15:0] num_pkts_i, seed_i;
    logic        fifo_wr_o, busy_o, done_o;
    logic [15:0] fifo_dat_o, pkt_cnt_o;
    logic [31:0] stall_cnt_o;

    down_fifo_pattern_writer #(.PKT_WORDS(P), .GAP_CYCLES(G)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i), .stop_i(stop_i),
        .num_pkts_i(num_pkts_i), .seed_i(seed_i), .fifo_full_i(fifo_full_i),
        .fifo_wr_o(fifo_wr_o), .fifo_dat_o(fifo_dat_o), .busy_o(busy_o), .done_o(done_o),
        .pkt_cnt_o(pkt_cnt_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        wr;
        logic [15:0] dat;
        logic        done;
        logic        busy;
    } vec_t;

    vec_t        tv[17];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] got[$];
    logic [15:0] exp_q[$];
    int          busy_cyc;
    bit          tmo;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference stream from the packet rules: header, seq, running payload, xor checksum.
    task automatic build_ref(input logic [15:0] seed, input int npk);
        logic [15:0] v, c;
        exp_q.delete();
        v = seed;
        for (int p = 0; p < npk; p++) begin
            exp_q.push_back(16'hBE11);
            exp_q.push_back(16'(p));
            c = 16'(p);
            for (int i = 0; i < P; i++) begin
                exp_q.push_back(v);
                c = c ^ v;
                v = v + 16'd1;
            end
            exp_q.push_back(c);
        end
    endtask

    task automatic run(input logic [15:0] seed, input logic [15:0] num, input int full_pct,
                       input int stop_at, input int restart_at, input bit stop_w_start,
                       input int win_lo, input int win_hi, input logic [15:0] hold_dat);
        bit stopped, restarted;
        got.delete();
        busy_cyc = 0; tmo = 1; stopped = 0; restarted = 0;
        @(negedge clk_i);
        start_i = 1; stop_i = stop_w_start; seed_i = seed; num_pkts_i = num; fifo_full_i = 0;
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk_i);
            start_i = 0; stop_i = 0;
            fifo_full_i = (k >= win_lo && k <= win_hi) || ($urandom_range(99) < full_pct);
            if (!stopped && got.size() == stop_at) begin stop_i = 1; stopped = 1; end
            if (!restarted && got.size() == restart_at) begin
                start_i = 1; seed_i = ~seed; num_pkts_i = num + 16'd3; restarted = 1;
            end
            #1;
            if (done_o) begin tmo = 0; break; end
            if (busy_o) busy_cyc++;
            if (k >= win_lo && k <= win_hi) begin
                check("stall_wr", 32'(fifo_wr_o), 32'd0);
                check("stall_hold", 32'(fifo_dat_o), 32'(hold_dat));
            end
            if (fifo_wr_o) got.push_back(fifo_dat_o);
        end
        fifo_full_i = 0; start_i = 0; stop_i = 0;
        check("run_timeout", 32'(tmo), 32'd0);
    endtask

    task automatic verify(input logic [15:0] seed, input int npk);
        int m;
        build_ref(seed, npk);
        check("stream_len", 32'(got.size()), 32'(exp_q.size()));
        m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < m; i++)
            check($sformatf("word[%0d]", i), 32'(got[i]), 32'(exp_q[i]));
        check("pkt_cnt", 32'(pkt_cnt_o), 32'(npk));
        check("stall_cnt", stall_cnt_o, 32'(busy_cyc - exp_q.size() - G * (npk - 1)));
        @(negedge clk_i); #1;
        check("done_pulse_len", 32'(done_o), 32'd0);
        check("idle_busy", 32'(busy_o), 32'd0);
    endtask

    function automatic vec_t mk(input logic wr, input logic [15:0] dat, input logic done, input logic busy);
        vec_t v;
        v.wr = wr; v.dat = dat; v.done = done; v.busy = busy;
        return v;
    endfunction

    initial begin
        tv[0]  = mk(1, 16'hBE11, 0, 1);  tv[1]  = mk(1, 16'h0000, 0, 1);
        tv[2]  = mk(1, 16'h0000, 0, 1);  tv[3]  = mk(1, 16'h0001, 0, 1);
        tv[4]  = mk(1, 16'h0002, 0, 1);  tv[5]  = mk(1, 16'h0003, 0, 1);
        tv[6]  = mk(1, 16'h0000, 0, 1);  tv[7]  = mk(0, 16'h0000, 0, 1);
        tv[8]  = mk(0, 16'h0000, 0, 1);  tv[9]  = mk(1, 16'hBE11, 0, 1);
        tv[10] = mk(1, 16'h0001, 0, 1);  tv[11] = mk(1, 16'h0004, 0, 1);
        tv[12] = mk(1, 16'h0005, 0, 1);  tv[13] = mk(1, 16'h0006, 0, 1);
        tv[14] = mk(1, 16'h0007, 0, 1);  tv[15] = mk(1, 16'h0001, 0, 1);
        tv[16] = mk(0, 16'h0000, 1, 0);

        reset_n_i = 0; start_i = 0; stop_i = 0; fifo_full_i = 0;
        num_pkts_i = 0; seed_i = 0;
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_wr", 32'(fifo_wr_o), 32'd0);
        check("rst_dat", 32'(fifo_dat_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_pkt", 32'(pkt_cnt_o), 32'd0);
        check("rst_stall", stall_cnt_o, 32'd0);
        reset_n_i = 1;

        // Cycle-exact two-packet run.
        @(negedge clk_i);
        start_i = 1; seed_i = 16'h0000; num_pkts_i = 16'd2;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk_i);
            start_i = 0;
            #1;
            check($sformatf("tv_wr[%0d]", k), 32'(fifo_wr_o), 32'(tv[k].wr));
            if (tv[k].wr) check($sformatf("tv_dat[%0d]", k), 32'(fifo_dat_o), 32'(tv[k].dat));
            check($sformatf("tv_done[%0d]", k), 32'(done_o), 32'(tv[k].done));
            check($sformatf("tv_busy[%0d]", k), 32'(busy_o), 32'(tv[k].busy));
        end
        check("tv_pkt", 32'(pkt_cnt_o), 32'd2);

        // Full held for 3 cycles while payload 0002 is pending.
        run(16'h0000, 16'd2, 0, -1, -1, 0, 5, 7, 16'h0002);
        check("stall_exact", stall_cnt_o, 32'd3);
        verify(16'h0000, 2);

        // Payload wrap through FFFF.
        run(16'hFFFE, 16'd1, 0, -1, -1, 0, 0, -1, 16'h0);
        check("wrap_chk", 32'((got.size() > 6) ? got[6] : 16'hDEAD), 32'h0000);
        verify(16'hFFFE, 1);

        // Continuous run, stop during payload of packet 3.
        run(16'h0100, 16'd0, 0, 7 * 3 + 3, -1, 0, 0, -1, 16'h0);
        verify(16'h0100, 4);

        // Start while busy must not re-latch seed or count.
        run(16'h1234, 16'd2, 0, -1, 3, 0, 0, -1, 16'h0);
        verify(16'h1234, 2);

        // Stop in IDLE ignored; start with simultaneous stop wins.
        @(negedge clk_i); stop_i = 1;
        @(negedge clk_i); stop_i = 0;
        run(16'h0042, 16'd2, 0, -1, -1, 1, 0, -1, 16'h0);
        verify(16'h0042, 2);

        // Asynchronous reset during the SEQ word.
        @(negedge clk_i);
        start_i = 1; seed_i = 16'h0000; num_pkts_i = 16'd2;
        @(negedge clk_i); start_i = 0;
        @(negedge clk_i); #1;
        check("pre_rst_wr", 32'(fifo_wr_o), 32'd1);
        check("pre_rst_seq", 32'(fifo_dat_o), 32'h0000);
        #1 reset_n_i = 0;
        #1;
        check("arst_wr", 32'(fifo_wr_o), 32'd0);
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_dat", 32'(fifo_dat_o), 32'd0);
        @(negedge clk_i); reset_n_i = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i); #1;
            check("post_rst_idle", 32'(busy_o), 32'd0);
        end
        run(16'h00AA, 16'd1, 0, -1, -1, 0, 0, -1, 16'h0);
        verify(16'h00AA, 1);

        // Randomized backpressure.
        for (int it = 0; it < 6; it++) begin
            logic [15:0] s;
            int n, pct;
            s = 16'($urandom);
            n = $urandom_range(1, 4);
            pct = $urandom_range(10, 50);
            run(s, 16'(n), pct, -1, -1, 0, 0, -1, 16'h0);
            verify(s, n);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
